// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage definitions, also used by decode and the hazard unit.
//   fetch_state_e : fetch sequencer state encoding (RUN / MISS / REPLAY)
//   NOP_INSTR     : instruction word used for IF/ID bubbles
//   DEF_RESET_PC  : default PC value after reset
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_MISS   = 2'b01,
    ST_REPLAY = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_fetch_unit_if_id_reg.sv
// IF/ID pipeline register with load enable and flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : capture instr_i / pc1_i as a valid instruction
//   flush_i    : insert a bubble (instr=NOP, valid=0); wins over load_i
//   instr_i    : fetched instruction
//   pc1_i      : return address (pc+1) of the fetched instruction
//   instr_o, pc1_o, valid_o : registered IF/ID contents
// With neither load_i nor flush_i the register holds (stall).
module pc_fetch_unit_if_id_reg
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_i,
  input  logic          flush_i,
  input  logic [DW-1:0] instr_i,
  input  logic [AW-1:0] pc1_i,
  output logic [DW-1:0] instr_o,
  output logic [AW-1:0] pc1_o,
  output logic          valid_o
);

  logic [DW-1:0] instr_q;
  logic [AW-1:0] pc1_q;
  logic          valid_q;

  // pc1 is left untouched by a bubble; it is meaningless while valid=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= DW'(NOP_INSTR);
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      instr_q <= DW'(NOP_INSTR);
      valid_q <= 1'b0;
    end else if (load_i) begin
      instr_q <= instr_i;
      pc1_q   <= pc1_i;
      valid_q <= 1'b1;
    end
  end

  assign instr_o = instr_q;
  assign pc1_o   = pc1_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage sequencer: PC register, cache-miss / stall / branch-flush
// sequencing, IF/ID pipeline register and a saturating miss counter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   next_addr    : next PC from the address generator (sequential or target)
//   pc_plus1     : pc+1 from the address generator (return address)
//   pcsrc        : branch taken, redirect to next_addr
//   hit          : I-cache hit for the current pc
//   instr_in     : I-cache read data for the current pc
//   fill_done    : one-cycle pulse, line fill complete
//   stall        : hazard unit hold of PC and IF/ID
//   pc           : current PC (cache address, generator Add_in)
//   fill_req     : level request to fill the line holding pc
//   if_id_instr, if_id_pc1, if_id_valid : IF/ID register contents
//   miss_cnt     : number of miss episodes, saturating at all-ones
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned    AW       = 32,
  parameter int unsigned    DW       = 32,
  parameter logic [AW-1:0]  RESET_PC = AW'(DEF_RESET_PC),
  parameter int unsigned    CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    next_addr,
  input  logic [AW-1:0]    pc_plus1,
  input  logic             pcsrc,
  input  logic             hit,
  input  logic [DW-1:0]    instr_in,
  input  logic             fill_done,
  input  logic             stall,
  output logic [AW-1:0]    pc,
  output logic             fill_req,
  output logic [DW-1:0]    if_id_instr,
  output logic [AW-1:0]    if_id_pc1,
  output logic             if_id_valid,
  output logic [CNT_W-1:0] miss_cnt
);

  fetch_state_e     state_q, state_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [AW-1:0]    redir_tgt_q, redir_tgt_d;
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             ifid_load, ifid_flush;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_tgt_d  = redir_tgt_q;
    redir_pend_d = redir_pend_q;
    miss_cnt_d   = miss_cnt_q;
    ifid_load    = 1'b0;
    ifid_flush   = 1'b0;

    case (state_q)
      ST_MISS: begin
        ifid_flush = !stall;
        if (fill_done) begin
          redir_pend_d = 1'b0;
          // A redirect makes the just-filled line irrelevant, so go straight
          // to RUN at the target instead of replaying the old pc.
          if (pcsrc) begin
            pc_d    = next_addr;
            state_d = ST_RUN;
          end else if (redir_pend_q) begin
            pc_d    = redir_tgt_q;
            state_d = ST_RUN;
          end else begin
            state_d = ST_REPLAY;
          end
        end else if (pcsrc) begin
          // The fill keeps running; remember only the latest target
          redir_tgt_d  = next_addr;
          redir_pend_d = 1'b1;
        end
      end

      // RUN and REPLAY share behaviour: REPLAY only exists so the cache
      // gets one cycle to re-read pc after the fill.
      default: begin
        state_d = ST_RUN;
        if (pcsrc) begin
          pc_d       = next_addr;
          ifid_flush = 1'b1;
        end else if (!stall) begin
          if (hit) begin
            pc_d      = next_addr;
            ifid_load = 1'b1;
          end else begin
            state_d    = ST_MISS;
            ifid_flush = 1'b1;
            miss_cnt_d = sat_inc(miss_cnt_q);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      pc_q         <= RESET_PC;
      redir_tgt_q  <= '0;
      redir_pend_q <= 1'b0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_tgt_q  <= redir_tgt_d;
      redir_pend_q <= redir_pend_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  pc_fetch_unit_if_id_reg #(
    .AW(AW),
    .DW(DW)
  ) u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (ifid_load),
    .flush_i (ifid_flush),
    .instr_i (instr_in),
    .pc1_i   (pc_plus1),
    .instr_o (if_id_instr),
    .pc1_o   (if_id_pc1),
    .valid_o (if_id_valid)
  );

  assign pc       = pc_q;
  assign fill_req = (state_q == ST_MISS);
  assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [31:0]      next_addr, pc_plus1, instr_in;
  logic             pcsrc, hit, fill_done, stall;
  logic [31:0]      pc, if_id_instr, if_id_pc1;
  logic             fill_req, if_id_valid;
  logic [CNT_W-1:0] miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the fetch stage
  logic [31:0] m_pc, m_tgt, m_instr, m_pc1;
  bit          m_valid, m_miss, m_pend;
  int          m_cnt;

  pc_fetch_unit #(
    .AW(32), .DW(32), .RESET_PC(32'd0), .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .next_addr   (next_addr),
    .pc_plus1    (pc_plus1),
    .pcsrc       (pcsrc),
    .hit         (hit),
    .instr_in    (instr_in),
    .fill_done   (fill_done),
    .stall       (stall),
    .pc          (pc),
    .fill_req    (fill_req),
    .if_id_instr (if_id_instr),
    .if_id_pc1   (if_id_pc1),
    .if_id_valid (if_id_valid),
    .miss_cnt    (miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0001;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_tgt = 0; m_instr = 0; m_pc1 = 0;
    m_valid = 0; m_miss = 0; m_pend = 0; m_cnt = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".fill_req"}, fill_req, m_miss);
    chk({tag, ".valid"}, if_id_valid, m_valid);
    chk({tag, ".instr"}, if_id_instr, m_instr);
    if (m_valid) chk({tag, ".pc1"}, if_id_pc1, m_pc1);
    chk({tag, ".miss_cnt"}, miss_cnt, m_cnt);
  endtask

  // Applies one cycle of inputs (called just after a negedge), advances the
  // model, then checks the DUT at the following negedge.
  task automatic step(input bit h, input bit st, input bit br, input bit fd,
                      input logic [31:0] na, input string tag);
    hit = h; stall = st; pcsrc = br; fill_done = fd; next_addr = na;
    pc_plus1 = m_pc + 32'd1;
    instr_in = mem(m_pc);
    if (m_miss) begin
      if (!st) begin m_instr = 0; m_valid = 0; end
      if (fd) begin
        if (br)          m_pc = na;
        else if (m_pend) m_pc = m_tgt;
        m_miss = 0;
        m_pend = 0;
      end else if (br) begin
        m_tgt  = na;
        m_pend = 1;
      end
    end else if (br) begin
      m_pc = na; m_instr = 0; m_valid = 0;
    end else if (!st) begin
      if (h) begin
        m_instr = mem(m_pc); m_pc1 = m_pc + 32'd1; m_valid = 1; m_pc = na;
      end else begin
        m_miss = 1; m_instr = 0; m_valid = 0;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  initial begin
    rst_n = 1'b0;
    next_addr = 0; pc_plus1 = 0; instr_in = 0;
    pcsrc = 0; hit = 0; fill_done = 0; stall = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_outputs("reset");

    // Sequential hits
    for (int i = 0; i < 4; i++) begin
      chk("seq.pc_before", pc, i);
      step(1, 0, 0, 0, m_pc + 1, "seq");
      chk("seq.pc1", if_id_pc1, i + 1);
    end
    step(1, 0, 0, 0, m_pc + 1, "to5");

    // Miss at pc=5, fill completes three cycles later
    chk("miss.pc", pc, 32'd5);
    step(0, 0, 0, 0, m_pc + 1, "miss_enter");
    chk("miss.req1", fill_req, 1'b1);
    step(0, 0, 0, 0, m_pc + 1, "miss_wait");
    chk("miss.req2", fill_req, 1'b1);
    step(0, 0, 0, 0, m_pc + 1, "miss_wait");
    chk("miss.req3", fill_req, 1'b1);
    step(0, 0, 0, 1, m_pc + 1, "miss_fill");
    chk("replay.req", fill_req, 1'b0);
    chk("replay.bubble", if_id_valid, 1'b0);
    step(1, 0, 0, 0, m_pc + 1, "replay");
    chk("replay.instr", if_id_instr, mem(32'd5));
    chk("replay.pc1", if_id_pc1, 32'd6);
    chk("replay.cnt", miss_cnt, 1);

    // Branch with stall asserted: flush still wins
    step(1, 1, 1, 0, 32'h40, "br_stall");
    chk("br_stall.pc", pc, 32'h40);
    chk("br_stall.valid", if_id_valid, 1'b0);

    // Redirect during a miss, last target wins, no replay
    step(0, 0, 0, 0, m_pc + 1, "miss2_enter");
    step(0, 0, 1, 0, 32'h70, "miss2_br1");
    step(0, 0, 1, 0, 32'h80, "miss2_br2");
    step(0, 0, 0, 0, 32'h0, "miss2_wait");
    step(0, 0, 0, 1, 32'h0, "miss2_fill");
    chk("redir.pc", pc, 32'h80);
    chk("redir.req", fill_req, 1'b0);
    step(1, 0, 0, 0, 32'h81, "redir_hit");
    chk("redir.instr", if_id_instr, mem(32'h80));

    // Asynchronous reset in the middle of a miss
    step(0, 0, 0, 0, m_pc + 1, "miss3_enter");
    step(0, 0, 0, 0, m_pc + 1, "miss3_wait");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0, 1, 32'd1, "post_rst_fd");
    chk("post_rst.pc", pc, 32'd1);
    chk("post_rst.req", fill_req, 1'b0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      bit h, st, br, fd;
      logic [31:0] na;
      h  = ($urandom_range(0, 99) < 75);
      st = ($urandom_range(0, 99) < 15);
      br = ($urandom_range(0, 99) < 10);
      if (m_miss) fd = ($urandom_range(0, 99) < 30);
      else        fd = ($urandom_range(0, 99) < 5);
      if (br) na = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFE : $urandom;
      else    na = m_pc + 32'd1;
      step(h, st, br, fd, na, "rand");
    end

    // Drive the miss counter well past its maximum
    for (int k = 0; k < CMAX + 4; k++) begin
      if (m_miss) step(0, 0, 0, 1, m_pc + 1, "sat_fill");
      step(0, 0, 0, 0, m_pc + 1, "sat_miss");
    end
    chk("cnt_saturated", miss_cnt, CMAX);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
